lane_stripe_scheduler: RTL and testbench

Sequences the transmit datapath between the MAC frame interface and the per-lane encoders. It accepts 32-bit MAC frames with a valid/ready handshake and stripes their bytes across the active lanes (x1/x2/x4). When no data is pending it fills the lanes with logical idle. At a fixed symbol-time interval it schedules a SKP ordered set on all active lanes, inserted only at frame boundaries. It sits between the top-level frame input and multi_lane_controller/encoders; link width and link-up come from pcie_controller.

---
 rtl/pcie_phys_pkg.sv | 37 +++
 rtl/skp_scheduler.sv | 51 +++++
 rtl/lane_stripe_scheduler.sv | 176 +++++++++++++++++
 tb/tb_lane_stripe_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_phys_pkg.sv
// Shared symbol constants, link width and striping state types.
package pcie_phys_pkg;

    localparam logic [7:0] K28_5_COM    = 8'hBC;
    localparam logic [7:0] K28_0_SKP    = 8'h1C;
    localparam logic [7:0] LOGICAL_IDLE = 8'h00;

    typedef enum logic [1:0] {X1 = 2'd0, X2 = 2'd1, X4 = 2'd2} link_width_e;
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, SKP = 2'd2} stripe_state_e;

    // Reserved width code falls back to a single lane.
    function automatic link_width_e decode_width(input logic [1:0] w);
        case (w)
            2'd1:    return X2;
            2'd2:    return X4;
            default: return X1;
        endcase
    endfunction

    function automatic logic [2:0] lane_count(input link_width_e w);
        case (w)
            X4:      return 3'd4;
            X2:      return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    // Index of the final chunk of a frame for a given width.
    function automatic logic [1:0] last_chunk(input link_width_e w);
        case (w)
            X4:      return 2'd0;
            X2:      return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/skp_scheduler.sv
// Symbol-time counter that raises a SKP request every SKP_INTERVAL counted cycles.
module skp_scheduler #(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_count_en,
    input  logic i_skp_done,
    input  logic i_clr,
    output logic o_skp_pending,
    output logic o_skp_pending_nxt
);
    localparam int CNT_W = $clog2(SKP_INTERVAL);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_pend;
    logic             w_pend_nxt;
    logic             w_wrap;

    // Next counter / pending value; the pending look-ahead lets the parent register ready.
    always_comb begin
        w_wrap     = i_count_en && (r_cnt == CNT_W'(SKP_INTERVAL - 1));
        w_cnt_nxt  = r_cnt;
        w_pend_nxt = r_pend | w_wrap;
        if (i_clr) begin
            w_cnt_nxt  = '0;
            w_pend_nxt = 1'b0;
        end else begin
            if (i_count_en)
                w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
            if (i_skp_done)
                w_pend_nxt = 1'b0;
        end
    end

    // Counter and pending flag state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_pend <= w_pend_nxt;
        end
    end

    assign o_skp_pending     = r_pend;
    assign o_skp_pending_nxt = w_pend_nxt;

endmodule

// File: rtl/lane_stripe_scheduler.sv
// Stripes MAC frames across x1/x2/x4 lanes, fills with logical idle and
// inserts SKP ordered sets at frame boundaries.
module lane_stripe_scheduler
    import pcie_phys_pkg::*;
#(
    parameter int NUM_LANES       = 4,
    parameter int MAC_FRAME_WIDTH = 32,
    parameter int SKP_INTERVAL    = 1180
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       link_up_i,
    input  logic [1:0]                 link_width_i,
    input  logic [MAC_FRAME_WIDTH-1:0] mac_data_frame_i,
    input  logic                       mac_data_frame_valid_i,
    output logic                       mac_data_frame_ready_o,
    output logic [8*NUM_LANES-1:0]     lane_symbol_o,
    output logic [NUM_LANES-1:0]       lane_symbol_k_o,
    output logic [NUM_LANES-1:0]       lane_symbol_valid_o,
    output logic                       skp_active_o
);
    stripe_state_e               r_state, w_state_nxt;
    link_width_e                 r_width, w_width_nxt;
    logic                        r_hold_vld, w_hold_vld_nxt;
    logic [MAC_FRAME_WIDTH-1:0]  r_hold, w_hold_nxt;
    logic [1:0]                  r_chunk, w_chunk_nxt;   // chunk currently on the lanes
    logic [1:0]                  r_skp_idx, w_skp_idx_nxt;

    logic                        w_accept;
    logic                        w_count_en;
    logic                        w_skp_done;
    logic                        w_clr;
    logic                        w_pend;
    logic                        w_pend_nxt;

    logic [NUM_LANES-1:0][7:0]   r_sym, w_sym_nxt;
    logic [NUM_LANES-1:0]        r_k, w_k_nxt;
    logic [NUM_LANES-1:0]        r_vld, w_vld_nxt;
    logic                        r_ready, w_ready_nxt;
    logic                        r_skp_active, w_skp_active_nxt;

    assign w_accept   = r_ready && mac_data_frame_valid_i;
    assign w_count_en = (r_state == DATA);

    skp_scheduler #(
        .SKP_INTERVAL(SKP_INTERVAL)
    ) u_skp_scheduler (
        .i_clk            (clk_i),
        .i_rst            (rst_i),
        .i_count_en       (w_count_en),
        .i_skp_done       (w_skp_done),
        .i_clr            (w_clr),
        .o_skp_pending    (w_pend),
        .o_skp_pending_nxt(w_pend_nxt)
    );

    // Next state, holding register and SKP sequencing.
    always_comb begin
        w_state_nxt    = r_state;
        w_width_nxt    = r_width;
        w_hold_vld_nxt = r_hold_vld;
        w_hold_nxt     = r_hold;
        w_chunk_nxt    = r_chunk;
        w_skp_idx_nxt  = r_skp_idx;
        w_skp_done     = 1'b0;
        w_clr          = 1'b0;
        if (!link_up_i) begin
            w_state_nxt    = IDLE;
            w_hold_vld_nxt = 1'b0;
            w_chunk_nxt    = 2'd0;
            w_skp_idx_nxt  = 2'd0;
            w_clr          = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt    = DATA;
                    w_width_nxt    = decode_width(link_width_i);
                    w_hold_vld_nxt = 1'b0;
                    w_chunk_nxt    = 2'd0;
                end
                DATA: begin
                    if (r_hold_vld && (r_chunk != last_chunk(r_width))) begin
                        w_chunk_nxt = r_chunk + 2'd1;
                    end else if (w_accept) begin
                        w_hold_vld_nxt = 1'b1;
                        w_hold_nxt     = mac_data_frame_i;
                        w_chunk_nxt    = 2'd0;
                    end else begin
                        // Frame drained (ready is low while pending, so nothing new arrived).
                        w_hold_vld_nxt = 1'b0;
                        w_chunk_nxt    = 2'd0;
                        if (w_pend) begin
                            w_state_nxt   = SKP;
                            w_skp_idx_nxt = 2'd0;
                        end
                    end
                end
                SKP: begin
                    if (r_skp_idx == 2'd3) begin
                        w_state_nxt   = DATA;
                        w_skp_done    = 1'b1;
                        w_skp_idx_nxt = 2'd0;
                    end else begin
                        w_skp_idx_nxt = r_skp_idx + 2'd1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Lane symbols for the coming cycle, derived from next-state values so outputs stay registered.
    always_comb begin
        int idx;
        idx              = 0;
        w_sym_nxt        = '0;
        w_k_nxt          = '0;
        w_vld_nxt        = '0;
        w_skp_active_nxt = (w_state_nxt == SKP);
        w_ready_nxt      = (w_state_nxt == DATA) && !w_pend_nxt &&
                           (!w_hold_vld_nxt || (w_chunk_nxt == last_chunk(w_width_nxt)));
        for (int l = 0; l < NUM_LANES; l++) begin
            if (3'(l) < lane_count(w_width_nxt)) begin
                case (w_state_nxt)
                    DATA: begin
                        idx          = int'(w_chunk_nxt) * int'(lane_count(w_width_nxt)) + l;
                        w_vld_nxt[l] = 1'b1;
                        w_sym_nxt[l] = w_hold_vld_nxt ? w_hold_nxt[8*idx +: 8] : LOGICAL_IDLE;
                    end
                    SKP: begin
                        w_vld_nxt[l] = 1'b1;
                        w_k_nxt[l]   = 1'b1;
                        w_sym_nxt[l] = (w_skp_idx_nxt == 2'd0) ? K28_5_COM : K28_0_SKP;
                    end
                    default: ;
                endcase
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_width      <= X1;
            r_hold_vld   <= 1'b0;
            r_hold       <= '0;
            r_chunk      <= 2'd0;
            r_skp_idx    <= 2'd0;
            r_sym        <= '0;
            r_k          <= '0;
            r_vld        <= '0;
            r_ready      <= 1'b0;
            r_skp_active <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_width      <= w_width_nxt;
            r_hold_vld   <= w_hold_vld_nxt;
            r_hold       <= w_hold_nxt;
            r_chunk      <= w_chunk_nxt;
            r_skp_idx    <= w_skp_idx_nxt;
            r_sym        <= w_sym_nxt;
            r_k          <= w_k_nxt;
            r_vld        <= w_vld_nxt;
            r_ready      <= w_ready_nxt;
            r_skp_active <= w_skp_active_nxt;
        end
    end

    assign mac_data_frame_ready_o = r_ready;
    assign lane_symbol_o          = r_sym;
    assign lane_symbol_k_o        = r_k;
    assign lane_symbol_valid_o    = r_vld;
    assign skp_active_o           = r_skp_active;

endmodule

// File: tb/tb_lane_stripe_scheduler.sv
// Bench for lane_stripe_scheduler: directed scenarios plus random traffic
// checked every cycle against a chunk-queue model of the striping rules.
module tb_lane_stripe_scheduler;
    localparam int SI = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_up;
    logic [1:0]  width;
    logic [31:0] data;
    logic        valid;
    wire         ready;
    wire  [31:0] sym;
    wire  [3:0]  k;
    wire  [3:0]  vld;
    wire         skp_act;

    always #5 clk = ~clk;

    lane_stripe_scheduler #(
        .NUM_LANES(4), .MAC_FRAME_WIDTH(32), .SKP_INTERVAL(SI)
    ) dut (
        .clk_i(clk), .rst_i(rst), .link_up_i(link_up), .link_width_i(width),
        .mac_data_frame_i(data), .mac_data_frame_valid_i(valid),
        .mac_data_frame_ready_o(ready), .lane_symbol_o(sym), .lane_symbol_k_o(k),
        .lane_symbol_valid_o(vld), .skp_active_o(skp_act)
    );

    int checks = 0;
    int failures = 0;

    // Model: what the link shows (0 off, 1 data, 2 SKP), chunks still to send, owed SKP.
    int          m_kind, m_phase, m_W, m_dcnt;
    bit          m_owe, m_show_vld, m_ready;
    logic [31:0] m_show;
    logic [31:0] m_q[$];
    logic [41:0] exp_b;
    wire  [41:0] obs = {ready, skp_act, vld, k, sym};

    function automatic void build_exp();
        logic [3:0]  mask;
        logic [31:0] s;
        mask = 4'((1 << m_W) - 1);
        s = '0;
        exp_b = '0;
        if (m_kind == 1) begin
            s = m_show_vld ? m_show : 32'h0;
            exp_b = {m_ready, 1'b0, mask, 4'h0, s};
        end else if (m_kind == 2) begin
            for (int l = 0; l < m_W; l++) s[8*l +: 8] = (m_phase == 0) ? 8'hBC : 8'h1C;
            exp_b = {1'b0, 1'b1, mask, mask, s};
        end
    endfunction

    function automatic void model_reset();
        m_kind = 0; m_phase = 0; m_W = 1; m_dcnt = 0;
        m_owe = 0; m_show_vld = 0; m_ready = 0; m_show = '0;
        m_q.delete();
        build_exp();
    endfunction

    function automatic void model_update();
        bit owe_old, acc;
        logic [63:0] cmask;
        if (rst || !link_up) begin
            model_reset();
            return;
        end
        case (m_kind)
            0: begin
                m_kind = 1;
                m_W = (width == 2'd2) ? 4 : (width == 2'd1) ? 2 : 1;
                m_show_vld = 0;
            end
            1: begin
                owe_old = m_owe;
                acc = m_ready && valid;
                m_dcnt++;
                if (m_dcnt == SI) begin m_dcnt = 0; m_owe = 1; end
                if (acc) begin
                    cmask = (64'd1 << (8 * m_W)) - 64'd1;
                    for (int c = 0; c < 4 / m_W; c++)
                        m_q.push_back(32'((64'(data) >> (8 * m_W * c)) & cmask));
                end
                if (m_q.size() > 0) begin
                    m_show = m_q.pop_front();
                    m_show_vld = 1;
                end else begin
                    m_show_vld = 0;
                    if (owe_old) begin m_kind = 2; m_phase = 0; end
                end
            end
            default: begin
                if (m_phase == 3) begin m_kind = 1; m_owe = 0; m_show_vld = 0; end
                else m_phase++;
            end
        endcase
        m_ready = (m_kind == 1) && (m_q.size() == 0) && !m_owe;
        build_exp();
    endfunction

    // Advance one clock: model consumes the inputs seen at the edge; return at negedge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [31:0] nz_frame();
        return $urandom | 32'h01010101;
    endfunction

    task automatic test_reset();
        rst = 1; link_up = 0; width = 0; data = 0; valid = 0;
        #1;
        model_reset();
        checks++;
        if (obs !== exp_b) begin failures++; $display("FAIL reset_state obs=%h exp=%h", obs, exp_b); end
        @(negedge clk);
        step();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== exp_b) begin failures++; $display("FAIL reset_link_down obs=%h exp=%h", obs, exp_b); end
        end
    endtask

    task automatic test_x4_frame();
        link_up = 0; step();
        link_up = 1; width = 2'd2; step();
        checks++;
        if (obs !== exp_b) begin failures++; $display("FAIL x4_enter obs=%h exp=%h", obs, exp_b); end
        data = 32'hDDCCBBAA; valid = 1;
        step();
        valid = 0;
        checks++;
        if (obs !== exp_b) begin failures++; $display("FAIL x4_model obs=%h exp=%h", obs, exp_b); end
        checks++;
        if ({sym, vld, k} !== {32'hDDCCBBAA, 4'hF, 4'h0})
            begin failures++; $display("FAIL x4_lanes got=%h/%h/%h need=DDCCBBAA/f/0", sym, vld, k); end
        step();
        checks++;
        if ({sym, vld, k} !== {32'h0, 4'hF, 4'h0})
            begin failures++; $display("FAIL x4_idle got=%h/%h/%h need=0/f/0", sym, vld, k); end
    endtask

    task automatic test_x1_stream();
        logic [31:0] fq[$];
        logic [63:0] got;
        int          nb;
        bit          acc;
        fq = '{32'h04030201, 32'h08070605};
        got = '0; nb = 0;
        link_up = 0; step();
        link_up = 1; width = 2'd0; step();
        for (int i = 0; i < 12; i++) begin
            valid = (fq.size() > 0);
            data  = valid ? fq[0] : 32'h0;
            acc   = ready && valid;
            step();
            if (acc) void'(fq.pop_front());
            checks++;
            if (obs !== exp_b) begin failures++; $display("FAIL x1_model obs=%h exp=%h", obs, exp_b); end
            checks++;
            if (vld[3:1] !== 3'b000) begin failures++; $display("FAIL x1_upper_valid got=%b need=000", vld[3:1]); end
            if (vld[0] && sym[7:0] != 8'h00) begin
                got = {sym[7:0], got[63:8]};
                nb++;
                checks++;
                if (ready !== (sym[7:0] == 8'h04 || sym[7:0] == 8'h08))
                    begin failures++; $display("FAIL x1_ready byte=%h ready=%b", sym[7:0], ready); end
            end
        end
        valid = 0;
        checks++;
        if (got !== 64'h0807060504030201 || nb != 8)
            begin failures++; $display("FAIL x1_order got=%h n=%0d need=0807060504030201 n=8", got, nb); end
    endtask

    task automatic test_skp_x2();
        logic [31:0] fq[$];
        logic [7:0]  exp_q[$], got_q[$];
        int          run, bad, skp_cyc;
        bit          acc;
        for (int f = 0; f < 14; f++) begin
            fq.push_back(nz_frame());
            for (int b = 0; b < 4; b++) exp_q.push_back(fq[f][8*b +: 8]);
        end
        run = 0; skp_cyc = 0;
        link_up = 0; step();
        link_up = 1; width = 2'd1; step();
        for (int i = 0; i < 60; i++) begin
            valid = (fq.size() > 0);
            data  = valid ? fq[0] : 32'h0;
            acc   = ready && valid;
            step();
            if (acc) void'(fq.pop_front());
            checks++;
            if (obs !== exp_b) begin failures++; $display("FAIL x2_model obs=%h exp=%h", obs, exp_b); end
            if (skp_act) begin
                run++; skp_cyc++;
                checks++;
                if ({sym[15:0], k[1:0], ready, vld} !== {(run == 1) ? 16'hBCBC : 16'h1C1C, 2'b11, 1'b0, 4'b0011})
                    begin failures++; $display("FAIL x2_skp run=%0d sym=%h k=%b rdy=%b vld=%b", run, sym[15:0], k, ready, vld); end
            end else begin
                if (run > 0) begin
                    checks++;
                    if (run != 4) begin failures++; $display("FAIL x2_skp_len got=%0d need=4", run); end
                end
                run = 0;
                if (vld[0] && sym[7:0] != 8'h00) begin
                    got_q.push_back(sym[7:0]);
                    got_q.push_back(sym[15:8]);
                end
            end
        end
        valid = 0;
        checks++;
        if (fq.size() != 0 || skp_cyc == 0 || (skp_cyc % 4) != 0)
            begin failures++; $display("FAIL x2_progress left=%0d skp_cycles=%0d", fq.size(), skp_cyc); end
        bad = (got_q.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL x2_stream bad=%0d got_n=%0d need_n=%0d", bad, got_q.size(), exp_q.size()); end
    endtask

    task automatic test_skp_offer();
        logic [31:0] fq[$];
        logic [31:0] held;
        bit          seen_skp, after_done, acc;
        seen_skp = 0; after_done = 0; held = '0;
        for (int f = 0; f < 30; f++) fq.push_back(nz_frame());
        link_up = 0; step();
        link_up = 1; width = 2'd2; step();
        for (int i = 0; i < 40; i++) begin
            valid = (fq.size() > 0);
            data  = valid ? fq[0] : 32'h0;
            acc   = ready && valid;
            if (skp_act && !seen_skp) begin
                seen_skp = 1; held = fq[0];
                checks++;
                if (ready !== 1'b0) begin failures++; $display("FAIL offer_ready_in_skp got=%b need=0", ready); end
            end
            step();
            if (acc) void'(fq.pop_front());
            checks++;
            if (obs !== exp_b) begin failures++; $display("FAIL offer_model obs=%h exp=%h", obs, exp_b); end
            if (seen_skp && !after_done && !skp_act && sym != 32'h0) begin
                after_done = 1;
                checks++;
                if (sym !== held) begin failures++; $display("FAIL offer_held got=%h need=%h", sym, held); end
            end
        end
        valid = 0;
        checks++;
        if (!after_done) begin failures++; $display("FAIL offer_no_resume seen_skp=%b", seen_skp); end
    endtask

    task automatic test_link_drop();
        int n;
        link_up = 0; step();
        link_up = 1; width = 2'd0; step();
        data = 32'h44332211; valid = 1; step();
        valid = 0; step(); step();
        checks++;
        if (sym[7:0] !== 8'h33) begin failures++; $display("FAIL drop_chunk2 got=%h need=33", sym[7:0]); end
        link_up = 0; step();
        checks++;
        if (obs !== 42'h0) begin failures++; $display("FAIL drop_data_out got=%h need=0", obs); end
        checks++;
        if (obs !== exp_b) begin failures++; $display("FAIL drop_model obs=%h exp=%h", obs, exp_b); end
        link_up = 1; width = 2'd2; step();
        n = 1;
        data = 32'hA4A3A2A1; valid = 1; step(); n++;
        valid = 0;
        checks++;
        if ({sym, vld} !== {32'hA4A3A2A1, 4'hF}) begin failures++; $display("FAIL relink_x4 got=%h/%h need=a4a3a2a1/f", sym, vld); end
        while (!skp_act && n < 40) begin
            step(); n++;
            checks++;
            if (obs !== exp_b) begin failures++; $display("FAIL relink_model obs=%h exp=%h", obs, exp_b); end
        end
        checks++;
        if (n != 18) begin failures++; $display("FAIL skp_restart_cycle got=%0d need=18", n); end
        step();
        checks++;
        if ({skp_act, sym} !== {1'b1, 32'h1C1C1C1C}) begin failures++; $display("FAIL skp_cycle1 got=%b/%h", skp_act, sym); end
        link_up = 0; step();
        checks++;
        if (obs !== 42'h0) begin failures++; $display("FAIL drop_skp_out got=%h need=0", obs); end
        link_up = 1; width = 2'd2; step();
        data = 32'h5A6B7C8D; valid = 1; step();
        valid = 0;
        checks++;
        if ({sym, vld, skp_act} !== {32'h5A6B7C8D, 4'hF, 1'b0}) begin failures++; $display("FAIL relink2 got=%h/%h/%b", sym, vld, skp_act); end
    endtask

    task automatic test_async_reset();
        link_up = 0; step();
        link_up = 1; width = 2'd0; step();
        data = 32'hCAFEBABE; valid = 1; step();
        valid = 0; step();
        #2 rst = 1;
        #1;
        checks++;
        if (obs !== 42'h0) begin failures++; $display("FAIL async_reset got=%h need=0", obs); end
        model_reset();
        link_up = 0;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ready !== 1'b0 || obs !== exp_b) begin failures++; $display("FAIL post_reset obs=%h exp=%h", obs, exp_b); end
        end
        link_up = 1; width = 2'd2; step();
        checks++;
        if (ready !== 1'b1 || obs !== exp_b) begin failures++; $display("FAIL post_reset_up obs=%h exp=%h", obs, exp_b); end
    endtask

    task automatic test_random();
        logic [31:0] hf;
        bit          hv, acc;
        hv = 0; hf = '0;
        for (int i = 0; i < 500; i++) begin
            if (link_up) begin
                if ($urandom_range(0, 79) == 0) link_up = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                link_up = 1;
            end
            width = 2'($urandom_range(0, 3));
            if (!hv && $urandom_range(0, 2) != 0) begin hv = 1; hf = $urandom; end
            valid = hv; data = hf;
            acc = ready && valid;
            step();
            if (acc) hv = 0;
            checks++;
            if (obs !== exp_b) begin failures++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs, exp_b); end
        end
        valid = 0;
    endtask

    initial begin
        test_reset();
        test_x4_frame();
        test_x1_stream();
        test_skp_x2();
        test_skp_offer();
        test_link_drop();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
